// File: rtl/knn_pkg.sv
// Shared definitions for the KNN memory subsystem (sample memory and memory_control).
package knn_pkg;

    localparam int unsigned DefW           = 8;
    localparam int unsigned DefAddressW    = 10;
    localparam int unsigned DefDepth       = 1024;
    localparam int unsigned DefReadLatency = 2;

    // Sample-memory operating mode: zeroing every word, or serving the bus.
    typedef enum logic [0:0] {
        CLEAR,
        SERVE
    } mem_state_t;

endpackage

// File: rtl/knn_rd_pipe.sv
// Read-return pipeline: LATENCY-deep valid/data shift register with synchronous flush.
// Each data stage only moves when its predecessor is valid, so the last stage holds
// the most recent returned word while out_valid is low.
module knn_rd_pipe #(
    parameter int unsigned W       = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [LATENCY-1:0] vld_q;
    logic [W-1:0]       dat_q [LATENCY];

    // Shift valid every cycle; advance data only behind a valid stage; flush on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/knn_sample_mem.sv
// On-chip sample memory for the KNN initiator: simple dual-port word storage with a
// self-clearing engine, waitrequest flow control and a pipelined read return path.
module knn_sample_mem
    import knn_pkg::*;
#(
    parameter int unsigned W            = DefW,
    parameter int unsigned ADDRESS_W    = DefAddressW,
    parameter int unsigned DEPTH        = DefDepth,
    parameter int unsigned READ_LATENCY = DefReadLatency
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 read,
    input  logic [ADDRESS_W-1:0] readaddress,
    output logic [W-1:0]         readdata,
    output logic                 readdatavalid,
    input  logic                 write,
    input  logic [ADDRESS_W-1:0] writeaddress,
    input  logic [W-1:0]         writedata,
    output logic                 waitrequest,
    output logic                 addr_error
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_W:0]   DepthW  = (ADDRESS_W + 1)'(DEPTH);
    localparam logic [ADDRESS_W-1:0] CntLast = ADDRESS_W'(DEPTH - 1);

    mem_state_t           state_q, state_d;
    logic [ADDRESS_W-1:0] cnt_q, cnt_d;

    logic [W-1:0]      mem [DEPTH];
    logic              mem_we;
    logic [IdxW-1:0]   mem_waddr;
    logic [W-1:0]      mem_wdata;

    logic rd_acc, wr_acc, rd_in_range, wr_in_range;
    logic [W-1:0] rd_word;

    assign waitrequest = (state_q != SERVE);
    assign rd_acc      = read && !waitrequest;
    assign wr_acc      = write && !waitrequest;
    assign rd_in_range = {1'b0, readaddress} < DepthW;
    assign wr_in_range = {1'b0, writeaddress} < DepthW;

    // Out-of-range reads return zero rather than whatever the truncated index hits.
    assign rd_word = rd_in_range ? mem[readaddress[IdxW-1:0]] : '0;

    // Mode register and clear counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next mode: sweep every word once, then serve until a clear pulse arrives.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDRESS_W'(1);
                if (cnt_q == CntLast) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
            end
            SERVE: begin
                if (clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Write-port mux: the clear engine owns the port while clearing; reset blocks all writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (rst) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[IdxW-1:0];
            end else if (wr_acc && wr_in_range) begin
                mem_we    = 1'b1;
                mem_waddr = writeaddress[IdxW-1:0];
                mem_wdata = writedata;
            end
        end
    end

    // Storage write port; reads are taken combinationally above, giving read-before-write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Sticky out-of-range flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_error <= 1'b0;
        end else if ((rd_acc && !rd_in_range) || (wr_acc && !wr_in_range)) begin
            addr_error <= 1'b1;
        end
    end

    knn_rd_pipe #(
        .W       (W),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (readdatavalid),
        .out_data  (readdata)
    );

endmodule
